// File: rtl/mem_bit_sender.sv
// Dumps a range of words from a registered-read memory as a serial bit stream,
// LSB first, with a one-cycle bitRdy strobe per bit and a done pulse at the end.
module mem_bit_sender #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W:0]   wordCount,
  input  logic              pause,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              ser_bit,
  output logic              bitRdy,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_STROBE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] shift_q;
  logic              last_bit_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is reset too, so no stale word can leak onto
      // the serial line after an aborted dump.
      state      <= S_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      last_bit_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q  <= baseAddr;
            count_q <= wordCount;
            state   <= (wordCount != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          shift_q <= memData;
          idx_q   <= '0;
          state   <= S_SETUP;
        end
        S_SETUP: begin
          if (!pause) state <= S_STROBE;
        end
        S_STROBE: begin
          // Remember the strobed bit so the line holds it between words.
          last_bit_q <= shift_q[0];
          shift_q    <= shift_q >> 1;
          idx_q      <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            addr_q  <= addr_q + 1'b1;
            count_q <= count_q - 1'b1;
            state   <= (count_q != (ADDR_W+1)'(1)) ? S_FETCH : S_DONE;
          end else begin
            state <= S_SETUP;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    memAddr = addr_q;
    memRd   = (state == S_FETCH);
    bitRdy  = (state == S_STROBE);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    ser_bit = (state == S_SETUP || state == S_STROBE) ? shift_q[0] : last_bit_q;
  end

endmodule

// File: tb/tb_mem_bit_sender.sv
// Scoreboard bench for mem_bit_sender: stimulus pushes expected reads, bits and
// done cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_bit_sender;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 2**ADDR_W;
  localparam int WORD_CYC = 2 + 2*DATA_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic [ADDR_W-1:0] baseAddr = '0;
  logic [ADDR_W:0]   wordCount = '0;
  logic [ADDR_W-1:0] memAddr;
  logic              memRd;
  logic [DATA_W-1:0] memData = '0;
  logic              ser_bit, bitRdy, busy, done;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] mem2 [8];

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  int   exp_addr [$];
  logic exp_bit  [$];
  int   exp_done [$];

  mem_bit_sender #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
    .wordCount(wordCount), .pause(pause), .memAddr(memAddr), .memRd(memRd),
    .memData(memData), .ser_bit(ser_bit), .bitRdy(bitRdy), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (memRd) memData <= mem[memAddr];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every read, strobe and done pulse against the queues.
  logic prev_bit = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (memRd === 1'b1) begin
        check("read pending", 64'(exp_addr.size() != 0), 64'd1);
        if (exp_addr.size() != 0) check("memAddr", 64'(memAddr), 64'(exp_addr.pop_front()));
      end
      if (bitRdy === 1'b1) begin
        check("bit stable before strobe", 64'(ser_bit), 64'(prev_bit));
        check("strobe pending", 64'(exp_bit.size() != 0), 64'd1);
        if (exp_bit.size() != 0) check("bit", 64'(ser_bit), 64'(exp_bit.pop_front()));
      end
      if (done === 1'b1) begin
        check("done pending", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) check("done cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
    end
    prev_bit <= ser_bit;
  end

  // Serial upload loader fed by the bit/bitRdy stream.
  logic              lb_clear = 1'b0;
  int                lb_bits = 0;
  int                lb_words = 0;
  logic [DATA_W-1:0] lb_shift = '0;
  always @(negedge clk) begin
    if (lb_clear) begin
      lb_bits  <= 0;
      lb_words <= 0;
    end else if (!reset && bitRdy === 1'b1) begin
      lb_shift <= {ser_bit, lb_shift[DATA_W-1:1]};
      if (lb_bits == DATA_W-1) begin
        if (lb_words < 8) mem2[lb_words] <= {ser_bit, lb_shift[DATA_W-1:1]};
        lb_words <= lb_words + 1;
        lb_bits  <= 0;
      end else begin
        lb_bits <= lb_bits + 1;
      end
    end
  end

  task automatic push_dump(input int base, input int count, input int s, input int extra);
    for (int w = 0; w < count; w++) begin
      int a;
      a = (base + w) % DEPTH;
      exp_addr.push_back(a);
      for (int b = 0; b < DATA_W; b++) exp_bit.push_back(mem[a][b]);
    end
    exp_done.push_back(s + count*WORD_CYC + extra);
  endtask

  task automatic do_start(input int base, input int count, input int extra, output int s);
    @(negedge clk);
    baseAddr  = ADDR_W'(base);
    wordCount = (ADDR_W+1)'(count);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    s = cyc;
    push_dump(base, count, s, extra);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < max);
    check("idle within budget", 64'(busy), 64'd0);
  endtask

  task automatic check_empty(input string name);
    check({name, " reads left"}, 64'(exp_addr.size()), 64'd0);
    check({name, " bits left"},  64'(exp_bit.size()),  64'd0);
    check({name, " done left"},  64'(exp_done.size()), 64'd0);
  endtask

  task automatic check_all_low(input string name);
    check({name, " memAddr"}, 64'(memAddr), 64'd0);
    check({name, " memRd"},   64'(memRd),   64'd0);
    check({name, " bit"},     64'(ser_bit), 64'd0);
    check({name, " bitRdy"},  64'(bitRdy),  64'd0);
    check({name, " busy"},    64'(busy),    64'd0);
    check({name, " done"},    64'(done),    64'd0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < DEPTH; i++) mem[i] = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    mem[5] = 32'hA5A5_0001;
    mem[9] = 32'h1234_56C3;

    repeat (3) @(negedge clk);
    check_all_low("reset");
    reset = 1'b0;

    // Single word from address 5: done in cycle 67.
    do_start(5, 1, 0, s);
    wait_idle(200);
    check_empty("single word");

    // Zero words: busy for one cycle with done, no reads or strobes.
    do_start(3, 0, 0, s);
    @(negedge clk);
    check("zero busy", 64'(busy), 64'd1);
    check("zero done", 64'(done), 64'd1);
    @(negedge clk);
    check("zero back idle", 64'(busy), 64'd0);
    check_empty("zero words");

    // Address wrap 1023 -> 0, with a start pulse mid-dump that must be ignored.
    do_start(1023, 2, 0, s);
    wait_cyc(s + 10);
    baseAddr  = 10'd7;
    wordCount = 11'd3;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400);
    check_empty("wrap");

    // Pause held for 10 cycles from the SETUP of bit 7.
    do_start(9, 1, 10, s);
    wait_cyc(s + 16);
    #1 pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("paused bitRdy", 64'(bitRdy), 64'd0);
      check("paused bit", 64'(ser_bit), 64'(mem[9][7]));
    end
    #1 pause = 1'b0;
    wait_idle(200);
    check_empty("pause");

    // Reset during bit 15 of word 2 of a 4-word dump, then a fresh dump.
    do_start(20, 4, 0, s);
    wait_cyc(s + WORD_CYC + 2 + 2*15);
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_all_low("mid-dump reset");
    end
    #1 reset = 1'b0;
    exp_addr.delete();
    exp_bit.delete();
    exp_done.delete();
    repeat (5) @(negedge clk);
    check("stays idle after reset", 64'(busy), 64'd0);
    do_start(40, 2, 0, s);
    wait_idle(300);
    check_empty("after reset");

    // Loopback of 8 random words into a second memory.
    lb_clear = 1'b1;
    @(negedge clk);
    #1 lb_clear = 1'b0;
    for (int i = 0; i < 8; i++) mem[200 + i] = $urandom;
    do_start(200, 8, 0, s);
    wait_idle(8*WORD_CYC + 20);
    check_empty("loopback");
    check("loopback words", 64'(lb_words), 64'd8);
    for (int i = 0; i < 8; i++) check("loopback data", 64'(mem2[i]), 64'(mem[200 + i]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
